// File: rtl/teclado_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package teclado_pkg;

  // Debounce/hold state machine states
  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD
  } estado_t;

  // Result of classifying one complete 16-bit scan snapshot
  typedef enum logic [1:0] {
    NONE,
    ONE,
    MULTI
  } classe_t;

  // Key codes: code = row*4 + column, standard phone-style membrane layout
  localparam logic [3:0] TECLA_1    = 4'd0;
  localparam logic [3:0] TECLA_2    = 4'd1;
  localparam logic [3:0] TECLA_3    = 4'd2;
  localparam logic [3:0] TECLA_A    = 4'd3;
  localparam logic [3:0] TECLA_4    = 4'd4;
  localparam logic [3:0] TECLA_5    = 4'd5;
  localparam logic [3:0] TECLA_6    = 4'd6;
  localparam logic [3:0] TECLA_B    = 4'd7;
  localparam logic [3:0] TECLA_7    = 4'd8;
  localparam logic [3:0] TECLA_8    = 4'd9;
  localparam logic [3:0] TECLA_9    = 4'd10;
  localparam logic [3:0] TECLA_C    = 4'd11;
  localparam logic [3:0] TECLA_AST  = 4'd12;
  localparam logic [3:0] TECLA_0    = 4'd13;
  localparam logic [3:0] TECLA_HASH = 4'd14;
  localparam logic [3:0] TECLA_D    = 4'd15;

  // Number of keys seen in a snapshot, folded into NONE / ONE / MULTI
  function automatic classe_t classificar(input logic [15:0] s);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      n = n + {4'd0, s[i]};
    end
    if (n == 5'd0) begin
      return NONE;
    end else if (n == 5'd1) begin
      return ONE;
    end else begin
      return MULTI;
    end
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set
  function automatic logic [3:0] codificar(input logic [15:0] s);
    logic [3:0] code;
    logic       found;
    code  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (s[i] && !found) begin
        code  = 4'(i);
        found = 1'b1;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (idle-high lines).
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Resets to all ones so pulled-up inputs read as inactive
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/teclado_matricial.sv
// 4x4 membrane keypad scanner: column drive, row readback, debounce,
// one key code per accepted press.
module teclado_matricial
  import teclado_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 250,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] linhas_in,
  output logic [3:0] colunas_out,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       tecla_pressionada,
  output logic       multipla
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic [3:0]        rows_sync;
  logic [3:0]        rows_n2p;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        col;
  logic [15:0]       snapshot;
  logic [15:0]       snap_full;
  logic              slot_end;
  logic              scan_end;
  classe_t           classe;
  logic [3:0]        codigo;
  estado_t           estado;
  logic [3:0]        cand;
  logic [3:0]        cnt;
  logic [3:0]        rel;

  sincronizador_2ff #(
    .WIDTH(4)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (linhas_in),
    .q    (rows_sync)
  );

  assign rows_n2p = ~rows_sync;
  assign slot_end = (slot == SLOT_LAST);
  assign scan_end = slot_end && (col == 2'd3);

  // Snapshot with the current column's rows merged in, so the scan-end
  // classification already sees the column being sampled this cycle
  always_comb begin
    snap_full = snapshot;
    for (int unsigned r = 0; r < 4; r++) begin
      snap_full[{r[1:0], col}] = rows_n2p[r];
    end
  end

  assign classe = classificar(snap_full);
  assign codigo = codificar(snap_full);

  // Slot/column counters, column drive and snapshot capture
  always_ff @(posedge clock) begin
    if (reset) begin
      slot        <= '0;
      col         <= '0;
      colunas_out <= 4'b1110;
      snapshot    <= '0;
    end else if (slot_end) begin
      slot        <= '0;
      col         <= col + 2'd1;
      colunas_out <= ~(4'b0001 << (col + 2'd1));
      snapshot    <= snap_full;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // Debounce/hold FSM and registered key outputs, advanced at scan end
  always_ff @(posedge clock) begin
    if (reset) begin
      estado            <= IDLE;
      cand              <= '0;
      cnt               <= '0;
      rel               <= '0;
      tecla             <= '0;
      tecla_valida      <= 1'b0;
      tecla_pressionada <= 1'b0;
      multipla          <= 1'b0;
    end else begin
      tecla_valida <= 1'b0;
      if (scan_end) begin
        multipla <= (classe == MULTI);
        case (estado)
          IDLE: begin
            if (classe == ONE) begin
              cand <= codigo;
              cnt  <= 4'd1;
              if (DS == 4'd1) begin
                tecla             <= codigo;
                tecla_valida      <= 1'b1;
                tecla_pressionada <= 1'b1;
                rel               <= '0;
                estado            <= HELD;
              end else begin
                estado <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if ((classe == ONE) && (codigo == cand)) begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DS) begin
                tecla             <= cand;
                tecla_valida      <= 1'b1;
                tecla_pressionada <= 1'b1;
                rel               <= '0;
                estado            <= HELD;
              end
            end else begin
              cnt    <= '0;
              estado <= IDLE;
            end
          end
          HELD: begin
            if (classe == NONE) begin
              rel <= rel + 4'd1;
              if (rel + 4'd1 == DS) begin
                tecla_pressionada <= 1'b0;
                cnt               <= '0;
                estado            <= IDLE;
              end
            end else begin
              rel <= '0;
            end
          end
          default: begin
            cnt    <= '0;
            rel    <= '0;
            estado <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
